// File: rtl/noc_packet_injector.sv
// rtl/noc_packet_injector.sv - NoC injection stage: request FIFO, sequence tagging, valid/ready output with idle gap
// Optional transfer/drop counters are built when NOC_INJ_STATS_EN is defined.
module noc_packet_injector #(
  parameter int packet_size = 16,
  parameter int DEST_W      = 4,
  parameter int SEQ_W       = 4,
  parameter int PAYLOAD_W   = 8,
  parameter int DEPTH       = 8,
  parameter int MIN_GAP     = 0
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_push,
  input  logic [DEST_W-1:0]      i_dest,
  input  logic [PAYLOAD_W-1:0]   i_payload,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_overflow,
  output logic [packet_size-1:0] o_data,
  output logic                   o_data_valid,
  input  logic                   i_ready
`ifdef NOC_INJ_STATS_EN
  ,
  output logic [15:0]            o_pkt_count,
  output logic [7:0]             o_drop_count
`endif
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int ENTRY_W = DEST_W + PAYLOAD_W;
  localparam int GAP_W   = $clog2(MIN_GAP + 2);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [ENTRY_W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, full_d, empty_q, empty_d;
  logic                   overflow_q, overflow_d;
  state_t                 state_q, state_d;
  logic [SEQ_W-1:0]       seq_q, seq_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [packet_size-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   push_ok, xfer, load;
  logic [ENTRY_W-1:0]     head;

  assign push_ok = i_push && !full_q;
  assign xfer    = valid_q && i_ready;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      seq_q      <= '0;
      gap_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      seq_q      <= seq_d;
      gap_cnt_q  <= gap_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!i_reset && push_ok) begin
      mem_q[wr_ptr_q] <= {i_dest, i_payload};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!empty_q) state_d = SEND;
      SEND: begin
        if (xfer) begin
          if (MIN_GAP > 0)  state_d = GAP;
          else if (empty_q) state_d = IDLE;
        end
      end
      GAP: if (gap_cnt_q == '0) state_d = empty_q ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load      = 1'b0;
    valid_d   = valid_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: load = !empty_q;
      SEND: begin
        if (xfer) begin
          if (MIN_GAP > 0) begin
            valid_d   = 1'b0;
            gap_cnt_d = GAP_INIT;
          end else if (!empty_q) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) load = !empty_q;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: valid_d = 1'b0;
    endcase

    // A packet loaded on the same edge as a transfer carries the advanced tag.
    seq_d  = xfer ? seq_q + 1'b1 : seq_q;
    data_d = data_q;
    if (load) begin
      data_d  = {head[ENTRY_W-1 -: DEST_W], seq_d, head[PAYLOAD_W-1:0]};
      valid_d = 1'b1;
    end

    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(load);
    full_d     = (count_d == CW'(DEPTH));
    empty_d    = (count_d == '0);
    overflow_d = overflow_q || (i_push && full_q);
  end

  assign o_full       = full_q;
  assign o_empty      = empty_q;
  assign o_overflow   = overflow_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;

`ifdef NOC_INJ_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  always_comb begin
    pkt_count_d  = pkt_count_q;
    drop_count_d = drop_count_q;
    if (xfer && pkt_count_q != 16'hFFFF)                pkt_count_d  = pkt_count_q + 16'd1;
    if (i_push && full_q && drop_count_q != 8'hFF)      drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign o_pkt_count  = pkt_count_q;
  assign o_drop_count = drop_count_q;
`endif

endmodule
